// File: rtl/fp_mul_round_stage.sv
// fp_mul_round_stage: two-stage back-end for the binary32 multiplier.
// Stage 1 classifies the operands and normalises the raw 48-bit hidden-bit
// product. Stage 2 rounds to nearest-even, resolves special cases, and packs
// the result together with {invalid, overflow, underflow, inexact}.
// A valid/ready handshake on both sides gives full throughput with
// backpressure.
module fp_mul_round_stage #(
  parameter int          FLUSH_DENORM = 1,
  parameter logic [31:0] QNAN         = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [47:0] prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  // Round-to-nearest-even on the 23-bit fraction. A carry out of the
  // fraction means the mantissa was all ones: it becomes 1.0 with the
  // exponent bumped, which is a zero fraction plus an exponent increment.
  function automatic logic [32:0] round_rne(input logic [22:0] frac,
                                            input logic g,
                                            input logic st,
                                            input logic signed [9:0] e);
    logic              rnd_up;
    logic [23:0]       frac_sum;
    logic signed [9:0] e_n;
    rnd_up   = g & (st | frac[0]);
    frac_sum = {1'b0, frac} + {23'd0, rnd_up};
    e_n      = e + $signed({9'd0, frac_sum[23]});
    return {e_n, frac_sum[22:0]};
  endfunction

  // Special-case priority and exponent saturation; returns {result, flags}.
  function automatic logic [35:0] pack_result(input logic sign,
                                              input logic nan,
                                              input logic infzero,
                                              input logic inf,
                                              input logic zero,
                                              input logic signed [9:0] e,
                                              input logic [22:0] frac,
                                              input logic inexact);
    if (nan)                  return {QNAN, 4'b0000};
    else if (infzero)         return {QNAN, 4'b1000};
    else if (inf)             return {sign, 8'hFF, 23'd0, 4'b0000};
    else if (zero)            return {sign, 31'd0, 4'b0000};
    else if (e >= 10'sd255)   return {sign, 8'hFF, 23'd0, 4'b0101};
    else if (e <= 10'sd0)     return {sign, 31'd0, 4'b0011};
    else                      return {sign, e[7:0], frac, 3'b000, inexact};
  endfunction

  logic s1_adv, s2_adv;
  logic vld_p1, vld_p2;

  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = s1_adv;

  // ---- Stage 1: classify operands, normalise product ----
  logic [7:0]        ea, eb;
  logic              frac_a_nz, frac_b_nz;
  logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic              sign_s1, nan_s1, infzero_s1, inf_s1, zero_s1;
  logic [23:0]       mant_s1;
  logic              g_s1, st_s1;
  logic signed [9:0] e_s1;

  assign ea        = op_a[30:23];
  assign eb        = op_b[30:23];
  assign frac_a_nz = |op_a[22:0];
  assign frac_b_nz = |op_b[22:0];
  // With denormal flushing any exp=0 operand is zero; otherwise only a true zero.
  assign zero_a    = (ea == 8'd0) && ((FLUSH_DENORM != 0) || !frac_a_nz);
  assign zero_b    = (eb == 8'd0) && ((FLUSH_DENORM != 0) || !frac_b_nz);
  assign inf_a     = (ea == 8'hFF) && !frac_a_nz;
  assign inf_b     = (eb == 8'hFF) && !frac_b_nz;
  assign nan_a     = (ea == 8'hFF) && frac_a_nz;
  assign nan_b     = (eb == 8'hFF) && frac_b_nz;

  assign sign_s1    = op_a[31] ^ op_b[31];
  assign nan_s1     = nan_a || nan_b;
  assign infzero_s1 = (inf_a && zero_b) || (zero_a && inf_b);
  assign inf_s1     = inf_a || inf_b;
  assign zero_s1    = zero_a || zero_b;

  assign mant_s1 = prod[47] ? prod[47:24] : prod[46:23];
  assign g_s1    = prod[47] ? prod[23]    : prod[22];
  assign st_s1   = prod[47] ? |prod[22:0] : |prod[21:0];
  assign e_s1    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
                 + $signed({9'd0, prod[47]});

  logic              sign_p1, nan_p1, infzero_p1, inf_p1, zero_p1;
  logic [23:0]       mant_p1;
  logic              g_p1, st_p1;
  logic signed [9:0] e_p1;

  // Stage 1 occupancy: refill whenever the stage can advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else if (s1_adv) vld_p1 <= in_valid;
  end

  // Stage 1 datapath capture on an accepted beat.
  always_ff @(posedge clk) begin
    if (in_valid && s1_adv) begin
      sign_p1    <= sign_s1;
      nan_p1     <= nan_s1;
      infzero_p1 <= infzero_s1;
      inf_p1     <= inf_s1;
      zero_p1    <= zero_s1;
      mant_p1    <= mant_s1;
      g_p1       <= g_s1;
      st_p1      <= st_s1;
      e_p1       <= e_s1;
    end
  end

  // ---- Stage 2: round, resolve specials, pack ----
  logic [32:0]       rnd_s2;
  logic signed [9:0] e_s2;
  logic [22:0]       frac_s2;
  logic [35:0]       pack_s2;
  logic              zero_eff_s2;

  assign rnd_s2          = round_rne(mant_p1[22:0], g_p1, st_p1, e_p1);
  assign {e_s2, frac_s2} = rnd_s2;
  // A product without a leading one can only come from a flushed operand.
  assign zero_eff_s2     = zero_p1 || !mant_p1[23];
  assign pack_s2         = pack_result(sign_p1, nan_p1, infzero_p1, inf_p1,
                                       zero_eff_s2, e_s2, frac_s2, g_p1 | st_p1);

  logic [31:0] result_p2;
  logic [3:0]  flags_p2;

  // Output register: holds while the consumer stalls, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      result_p2 <= 32'd0;
      flags_p2  <= 4'd0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        result_p2 <= pack_s2[35:4];
        flags_p2  <= pack_s2[3:0];
      end
    end
  end

  assign out_valid = vld_p2;
  assign result    = result_p2;
  assign flags     = flags_p2;

endmodule

// File: tb/tb_fp_mul_round_stage.sv
// Bench for fp_mul_round_stage: table of operand pairs with expected
// results, a scoreboard queue filled on accept and drained on output, plus
// backpressure and mid-flight reset sequences.
module tb_fp_mul_round_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic [47:0] prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  fp_mul_round_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .prod     (prod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  localparam int NV = 20;
  vec_t vecs[NV];
  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [47:0] mkprod(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] x, y;
    x = {24'd0, 1'b1, a[22:0]};
    y = {24'd0, 1'b1, b[22:0]};
    return x * y;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: every output transfer must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", result);
      end else begin
        e = q.pop_front();
        chk("result", result, e.r);
        chk("flags", {28'd0, flags}, {28'd0, e.f});
      end
    end
  end

  task automatic set_in(input vec_t v);
    in_valid = 1'b1;
    op_a     = v.a;
    op_b     = v.b;
    prod     = mkprod(v.a, v.b);
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.r = v.r;
    e.f = v.f;
    q.push_back(e);
  endtask

  // Present one beat and hold it until accepted; called at posedge+1.
  task automatic send(input vec_t v);
    int n;
    n = 0;
    set_in(v);
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=%b required=1", in_ready);
    end else begin
      push_exp(v);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1]  = '{32'hC0400000, 32'h3F000000, 32'hBFC00000, 4'b0000};
    vecs[2]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001};
    vecs[3]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
    vecs[4]  = '{32'h3F800002, 32'h3FA00000, 32'h3FA00002, 4'b0001}; // tie, even: hold
    vecs[5]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001}; // tie, odd: up
    vecs[6]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
    vecs[7]  = '{32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000};
    vecs[8]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101};
    vecs[9]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011};
    vecs[10] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000};
    vecs[11] = '{32'h7F800001, 32'h7F800000, 32'h7FC00000, 4'b0000};
    vecs[12] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
    vecs[13] = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000};
    vecs[14] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000}; // denorm flushed
    vecs[15] = '{32'h7F7FFFFE, 32'h3F800001, 32'h7F800000, 4'b0101}; // carry 254->255
    vecs[16] = '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'b0001}; // carry, normal
    vecs[17] = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011}; // e = 0
    vecs[18] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000}; // e = 1
    vecs[19] = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 4'b0000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    prod      = '0;
    out_ready = 1'b1;

    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-throughput pass over the table.
    for (int i = 0; i < NV; i++) send(vecs[i]);
    drain();

    // Backpressure: two beats fill the pipe, the third waits.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_in(vecs[i]);
      @(negedge clk);
      chk("bp_in_ready_open", {31'd0, in_ready}, 32'd1);
      push_exp(vecs[i]);
      @(posedge clk);
      #1;
    end
    set_in(vecs[2]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result_hold", result, vecs[0].r);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
    push_exp(vecs[2]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(vecs[3]);
    send(vecs[4]);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(vecs[5]);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
